// File: rtl/ss_xfer_fifo.sv
// ss_xfer_fifo: 64-bit FWFT elastic buffer between source and dest ss_sg engines.
// Generates start/stop/end flow-control strobes for both engines from fill level.
module ss_xfer_fifo #(
    parameter int AW    = 4,
    parameter int HI_WM = 12,
    parameter int LO_WM = 4,
    parameter int WR_WM = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          job_start,
    input  logic          job_done,
    input  logic          rd_xfer,
    input  logic          rd_last,
    input  logic [63:0]   rd_dat,
    output logic          rd_start,
    output logic          rd_stop,
    output logic          rd_end,
    input  logic          wr_xfer,
    output logic [63:0]   wr_dat,
    output logic          wr_start,
    output logic          wr_stop,
    output logic          wr_end,
    output logic [AW:0]   fifo_cnt,
    output logic          ovf_err,
    output logic          udf_err,
    output logic          c_done
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] HI_C   = (AW+1)'(HI_WM - 1);
    localparam logic [AW:0] LO_C   = (AW+1)'(LO_WM);
    localparam logic [AW:0] WR_C   = (AW+1)'(WR_WM);
    localparam logic [AW:0] ONE_C  = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_END
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            eof_q, eof_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic [63:0]     mem_q [DEPTH];

    logic in_idle, in_run, in_drain, in_end;
    logic empty, full, clr;
    logic push_en, pop_en, push_ok, pop_ok;

    assign in_idle  = (state_q == S_IDLE);
    assign in_run   = (state_q == S_RUN);
    assign in_drain = (state_q == S_DRAIN);
    assign in_end   = (state_q == S_END);
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FULL_C);
    assign clr      = in_idle & job_start;
    assign push_en  = rd_xfer & in_run;
    assign pop_en   = wr_xfer & (in_run | in_drain);
    assign pop_ok   = pop_en & ~empty;
    // A same-cycle pop frees the slot, so a push into full is then legal.
    assign push_ok  = push_en & (~full | pop_ok);

    // Pointer, occupancy and sticky-flag next state.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        eof_d  = eof_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            eof_d  = 1'b0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok)  rptr_d = rptr_q + 1'b1;
            if (push_ok & ~pop_ok) cnt_d = cnt_q + ONE_C;
            if (pop_ok & ~push_ok) cnt_d = cnt_q - ONE_C;
            if (push_en & full & ~pop_ok) ovf_d = 1'b1;
            if (pop_en & empty) udf_d = 1'b1;
            if (push_en & rd_last) eof_d = 1'b1;
        end
    end

    // Job sequencing: run, drain remaining entries, then hold until acknowledged.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (job_start) state_d = S_RUN;
            S_RUN:   if (rd_xfer & rd_last) state_d = S_DRAIN;
            S_DRAIN: if (cnt_d == '0) state_d = S_END;
            S_END:   if (job_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            eof_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            eof_q   <= eof_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem_q[wptr_q] <= rd_dat;
    end

    // Empty reads return zero so stale storage never leaks out.
    assign wr_dat   = empty ? '0 : mem_q[rptr_q];
    assign rd_start = in_run & (cnt_q <= LO_C);
    assign rd_stop  = (cnt_q >= HI_C) | rd_last;
    assign rd_end   = in_drain | in_end;
    // eof is only set once the source finished, so it stands in for DRAIN.
    assign wr_start = (in_run & (cnt_q >= WR_C)) | (eof_q & ~empty);
    assign wr_stop  = (in_run | in_drain) & (cnt_q <= ONE_C) & ~push_en;
    assign wr_end   = in_end;
    assign fifo_cnt = cnt_q;
    assign ovf_err  = ovf_q;
    assign udf_err  = udf_q;
    assign c_done   = in_idle | in_end;

endmodule

// File: tb/tb_ss_xfer_fifo.sv
// tb_ss_xfer_fifo: queue-based reference model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_ss_xfer_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_start = 1'b0;
    logic        job_done = 1'b0;
    logic        rd_xfer = 1'b0;
    logic        rd_last = 1'b0;
    logic [63:0] rd_dat = '0;
    logic        wr_xfer = 1'b0;
    logic        rd_start, rd_stop, rd_end;
    logic        wr_start, wr_stop, wr_end;
    logic [63:0] wr_dat;
    logic [4:0]  fifo_cnt;
    logic        ovf_err, udf_err, c_done;

    int tests = 0;
    int fails = 0;
    bit go = 1'b0;

    always #5 clk = ~clk;

    ss_xfer_fifo dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .job_start  (job_start),
        .job_done   (job_done),
        .rd_xfer    (rd_xfer),
        .rd_last    (rd_last),
        .rd_dat     (rd_dat),
        .rd_start   (rd_start),
        .rd_stop    (rd_stop),
        .rd_end     (rd_end),
        .wr_xfer    (wr_xfer),
        .wr_dat     (wr_dat),
        .wr_start   (wr_start),
        .wr_stop    (wr_stop),
        .wr_end     (wr_end),
        .fifo_cnt   (fifo_cnt),
        .ovf_err    (ovf_err),
        .udf_err    (udf_err),
        .c_done     (c_done)
    );

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_END} mst_e;
    mst_e        mst = M_IDLE;
    logic [63:0] q[$];
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue plus job phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mst = M_IDLE;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            case (mst)
                M_IDLE: if (job_start) begin
                    q.delete();
                    m_ovf = 1'b0;
                    m_udf = 1'b0;
                    mst = M_RUN;
                end
                M_RUN, M_DRAIN: begin
                    if (wr_xfer) begin
                        if (q.size() == 0) m_udf = 1'b1;
                        else void'(q.pop_front());
                    end
                    if (mst == M_RUN && rd_xfer) begin
                        if (q.size() < 16) q.push_back(rd_dat);
                        else m_ovf = 1'b1;
                    end
                    if (mst == M_RUN && rd_xfer && rd_last) mst = M_DRAIN;
                    else if (mst == M_DRAIN && q.size() == 0) mst = M_END;
                end
                M_END: if (job_done) mst = M_IDLE;
                default: mst = M_IDLE;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (go) begin
            int n;
            logic [63:0] head;
            n = q.size();
            head = (n != 0) ? q[0] : 64'h0;
            chk("cnt", 64'(fifo_cnt), 64'(n));
            chk("wr_dat", wr_dat, head);
            chk("rd_start", 64'(rd_start), 64'(mst == M_RUN && n <= 4));
            chk("rd_stop", 64'(rd_stop), 64'(n >= 11 || rd_last));
            chk("rd_end", 64'(rd_end), 64'(mst == M_DRAIN || mst == M_END));
            chk("wr_start", 64'(wr_start),
                64'((mst == M_RUN && n >= 8) || (mst == M_DRAIN && n != 0)));
            chk("wr_stop", 64'(wr_stop),
                64'((mst == M_RUN || mst == M_DRAIN) && n <= 1 &&
                    !(rd_xfer && mst == M_RUN)));
            chk("wr_end", 64'(wr_end), 64'(mst == M_END));
            chk("c_done", 64'(c_done), 64'(mst == M_IDLE || mst == M_END));
            chk("ovf", 64'(ovf_err), 64'(m_ovf));
            chk("udf", 64'(udf_err), 64'(m_udf));
        end
    end

    task automatic cyc(bit px, bit pl, logic [63:0] pd, bit pp, bit js, bit jd);
        rd_xfer = px;
        rd_last = pl;
        rd_dat = pd;
        wr_xfer = pp;
        job_start = js;
        job_done = jd;
        @(posedge clk);
        #1;
        rd_xfer = 1'b0;
        rd_last = 1'b0;
        rd_dat = '0;
        wr_xfer = 1'b0;
        job_start = 1'b0;
        job_done = 1'b0;
        #1;
    endtask

    task automatic push(logic [63:0] d, bit last);
        cyc(1'b1, last, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic both(logic [63:0] d);
        cyc(1'b1, 1'b0, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic jstart();
        cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic jdone();
        cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        go = 1'b1;
        chk("rst_cnt", 64'(fifo_cnt), 64'd0);
        chk("rst_cdone", 64'(c_done), 64'd1);
        rst_n = 1'b1;
        #1;

        // T1: asynchronous reset in the middle of a job
        jstart();
        for (int i = 1; i <= 5; i++) push(64'(i), 1'b0);
        chk("t1_cnt5", 64'(fifo_cnt), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("t1_cnt", 64'(fifo_cnt), 64'd0);
        chk("t1_cdone", 64'(c_done), 64'd1);
        chk("t1_strobes",
            64'({rd_start, rd_stop, rd_end, wr_start, wr_stop, wr_end}), 64'd0);
        chk("t1_wr_dat", wr_dat, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // T2: fill to the source stop mark, then drain in order
        jstart();
        for (int i = 1; i <= 10; i++) push(64'(i), 1'b0);
        chk("t2_stop10", 64'(rd_stop), 64'd0);
        push(64'd11, 1'b0);
        chk("t2_cnt11", 64'(fifo_cnt), 64'd11);
        chk("t2_stop11", 64'(rd_stop), 64'd1);
        for (int i = 1; i <= 11; i++) begin
            chk("t2_order", wr_dat, 64'(i));
            pop();
        end
        chk("t2_empty", 64'(fifo_cnt), 64'd0);

        // T3: steady push+pop at count 7 across pointer wrap
        for (int i = 0; i < 7; i++) push(64'h200 + 64'(i), 1'b0);
        for (int i = 0; i < 20; i++) both(64'h300 + 64'(i));
        chk("t3_cnt", 64'(fifo_cnt), 64'd7);
        chk("t3_head", wr_dat, 64'h30D);
        for (int i = 0; i < 7; i++) pop();

        // T4: end of data, drain, acknowledge
        push(64'hA1, 1'b0);
        push(64'hA2, 1'b0);
        push(64'hA3, 1'b1);
        chk("t4_rd_end", 64'(rd_end), 64'd1);
        chk("t4_wr_start", 64'(wr_start), 64'd1);
        chk("t4_cnt", 64'(fifo_cnt), 64'd3);
        chk("t4_cdone0", 64'(c_done), 64'd0);
        for (int i = 0; i < 3; i++) pop();
        chk("t4_wr_end", 64'(wr_end), 64'd1);
        chk("t4_cdone1", 64'(c_done), 64'd1);
        jdone();
        chk("t4_idle_end", 64'(wr_end), 64'd0);
        chk("t4_idle_rd_end", 64'(rd_end), 64'd0);

        // T5: overflow then underflow
        jstart();
        for (int i = 0; i < 16; i++) push(64'h400 + 64'(i), 1'b0);
        chk("t5_cnt16", 64'(fifo_cnt), 64'd16);
        chk("t5_ovf0", 64'(ovf_err), 64'd0);
        push(64'hDEAD, 1'b0);
        chk("t5_ovf", 64'(ovf_err), 64'd1);
        chk("t5_cnt", 64'(fifo_cnt), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t5_order", wr_dat, 64'h400 + 64'(i));
            pop();
        end
        chk("t5_gone", wr_dat, 64'd0);
        pop();
        chk("t5_udf", 64'(udf_err), 64'd1);
        chk("t5_cnt0", 64'(fifo_cnt), 64'd0);

        // T6: watermark strobes
        for (int i = 0; i < 7; i++) push(64'h500 + 64'(i), 1'b0);
        chk("t6_wr_start7", 64'(wr_start), 64'd0);
        push(64'h507, 1'b0);
        chk("t6_wr_start8", 64'(wr_start), 64'd1);
        chk("t6_rd_start8", 64'(rd_start), 64'd0);
        for (int i = 0; i < 4; i++) pop();
        chk("t6_rd_start4", 64'(rd_start), 64'd1);
        for (int i = 0; i < 3; i++) pop();
        chk("t6_cnt1", 64'(fifo_cnt), 64'd1);
        chk("t6_wr_stop", 64'(wr_stop), 64'd1);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
